// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit
//
// Hazard/interlock unit that sits beside the ID stage of the pipelined CPU.
// It keeps a small shift register of the register writes still in flight in
// the STAGES stages after ID. From that record it generates:
//   - operand forwarding selects,
//   - load-use stalls,
//   - bubble insertion into ID/EXE,
//   - the IF/ID flush on a taken branch.
//
// Parameters
//   RA_W      register-address width (r0 is hard-wired zero, never a hazard)
//   STAGES    tracked stages after ID (1 = EXE, 2 = MEM, 3 = WB, ...), >= 2
//   LOAD_LAT  stage index at whose output load data is first forwardable
//
// Build option
//   HAZ_FWD_EN  When defined, forwarding is enabled and only load-use
//               hazards stall. When undefined, the forwarding selects are
//               tied to 0, and any used source produced in stages
//               1..STAGES-1 stalls. Stage STAGES relies on the register file
//               writing before it is read.
//
// Ports
//   Clock         in   rising-edge clock
//   Resetn        in   asynchronous active-low reset
//   id_valid      in   ID holds a real instruction
//   id_rs, id_rt  in   ID source registers
//   id_use_rs/rt  in   ID actually reads rs / rt
//   id_wreg       in   ID instruction writes a register
//   id_m2reg      in   ID instruction is a load
//   id_rd         in   ID destination register
//   branch_taken  in   ID resolved a taken branch/jump
//   ext_hold      in   external freeze (e.g. memory wait)
//   fwd_a_sel     out  0 = regfile, k = result of stage k, for rs
//   fwd_b_sel     out  same, for rt
//   pc_wen        out  PC write enable
//   ifid_wen      out  IF/ID register write enable
//   ifid_flush    out  IF/ID register clear to NOP
//   idexe_bubble  out  ID/EXE receives a NOP instead of ID
// ---------------------------------------------------------------------------
module pipe_hazard_unit #(
    parameter int RA_W     = 5,
    parameter int STAGES   = 3,
    parameter int LOAD_LAT = 2
) (
    input  logic                           Clock,
    input  logic                           Resetn,
    input  logic                           id_valid,
    input  logic [RA_W-1:0]                id_rs,
    input  logic [RA_W-1:0]                id_rt,
    input  logic                           id_use_rs,
    input  logic                           id_use_rt,
    input  logic                           id_wreg,
    input  logic                           id_m2reg,
    input  logic [RA_W-1:0]                id_rd,
    input  logic                           branch_taken,
    input  logic                           ext_hold,
    output logic [$clog2(STAGES+1)-1:0]    fwd_a_sel,
    output logic [$clog2(STAGES+1)-1:0]    fwd_b_sel,
    output logic                           pc_wen,
    output logic                           ifid_wen,
    output logic                           ifid_flush,
    output logic                           idexe_bubble
);

    localparam int SEL_W = $clog2(STAGES + 1);

    // Tracker: index k holds the instruction currently k stages past ID.
    logic            ent_v     [1:STAGES];
    logic            ent_wreg  [1:STAGES];
    logic            ent_m2reg [1:STAGES];
    logic [RA_W-1:0] ent_rd    [1:STAGES];

    logic stall;

    // A tracked write only counts if it is live, really writes, and is not r0.
    function automatic logic reg_match(input logic            v,
                                       input logic            wreg,
                                       input logic [RA_W-1:0] rd,
                                       input logic [RA_W-1:0] src);
        return v && wreg && (rd == src) && (src != '0);
    endfunction

    // ---- tracker: valid bits (reset discards everything in flight) ----
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 1; k <= STAGES; k++) begin
                ent_v[k] <= 1'b0;
            end
        end else if (!ext_hold) begin
            // A stalled ID instruction stays in ID; EXE gets a bubble.
            ent_v[1] <= id_valid & ~stall;
            for (int k = 2; k <= STAGES; k++) begin
                ent_v[k] <= ent_v[k-1];
            end
        end
    end

    // ---- tracker: payload (meaningless while the matching valid is 0) ----
    always_ff @(posedge Clock) begin
        if (!ext_hold) begin
            ent_wreg[1]  <= id_wreg;
            ent_m2reg[1] <= id_m2reg;
            ent_rd[1]    <= id_rd;
            for (int k = 2; k <= STAGES; k++) begin
                ent_wreg[k]  <= ent_wreg[k-1];
                ent_m2reg[k] <= ent_m2reg[k-1];
                ent_rd[k]    <= ent_rd[k-1];
            end
        end
    end

`ifdef HAZ_FWD_EN
    localparam logic [SEL_W-1:0] LOAD_SEL = SEL_W'(LOAD_LAT);

    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             ld_a;
    logic             ld_b;

    // Scan oldest to youngest so the youngest producer wins.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (id_use_rs && reg_match(ent_v[k], ent_wreg[k], ent_rd[k], id_rs)) begin
                sel_a = SEL_W'(k);
                ld_a  = ent_m2reg[k];
            end
            if (id_use_rt && reg_match(ent_v[k], ent_wreg[k], ent_rd[k], id_rt)) begin
                sel_b = SEL_W'(k);
                ld_b  = ent_m2reg[k];
            end
        end
    end

    // Load data becomes forwardable once the load reaches LOAD_LAT; only a
    // younger load (closer to ID) forces a wait.
    assign stall = id_valid &&
                   ((ld_a && (sel_a != '0) && (sel_a < LOAD_SEL)) ||
                    (ld_b && (sel_b != '0) && (sel_b < LOAD_SEL)));

    assign fwd_a_sel = sel_a;
    assign fwd_b_sel = sel_b;
`else
    logic dep;

    // Without forwarding every producer still ahead of writeback blocks ID.
    always_comb begin
        dep = 1'b0;
        for (int k = 1; k <= STAGES - 1; k++) begin
            if ((id_use_rs && reg_match(ent_v[k], ent_wreg[k], ent_rd[k], id_rs)) ||
                (id_use_rt && reg_match(ent_v[k], ent_wreg[k], ent_rd[k], id_rt))) begin
                dep = 1'b1;
            end
        end
    end

    assign stall     = id_valid && dep;
    assign fwd_a_sel = '0;
    assign fwd_b_sel = '0;
`endif

    // ext_hold freezes the front end outright. A branch seen during a stall
    // is dropped here and re-evaluated once the stall clears.
    assign pc_wen       = ~ext_hold & ~stall;
    assign ifid_wen     = ~ext_hold & ~stall;
    assign idexe_bubble = ~ext_hold & stall;
    assign ifid_flush   = ~ext_hold & branch_taken & ~stall;

endmodule
